// File: rtl/timer_chime_if.sv
// timer_chime_if
// Bundles the control and annunciator signals of timer_chime_ctrl.
//   master : driven by whoever supplies the controls (set buttons, alarm slots, stop)
//   slave  : timer_chime_ctrl itself, producing BCD time, tick, buzzer code, alarm_hit
// Slot k of alarm_time occupies bits [16k+15:16k] as {h1,h2,m1,m2} in BCD.
interface timer_chime_if #(
  parameter int NUM_ALARMS = 2
);
  logic                        set_min;
  logic                        set_hour;
  logic [NUM_ALARMS-1:0]       alarm_en;
  logic [16*NUM_ALARMS-1:0]    alarm_time;
  logic                        alarm_stop;
  logic [3:0]                  h1;
  logic [3:0]                  h2;
  logic [3:0]                  m1;
  logic [3:0]                  m2;
  logic [3:0]                  s1;
  logic [3:0]                  s2;
  logic                        tick;
  logic [1:0]                  bee_in;
  logic [NUM_ALARMS-1:0]       alarm_hit;

  modport master (
    output set_min, set_hour, alarm_en, alarm_time, alarm_stop,
    input  h1, h2, m1, m2, s1, s2, tick, bee_in, alarm_hit
  );

  modport slave (
    input  set_min, set_hour, alarm_en, alarm_time, alarm_stop,
    output h1, h2, m1, m2, s1, s2, tick, bee_in, alarm_hit
  );
endinterface

// File: rtl/timer_chime_ctrl.sv
// timer_chime_ctrl
// Single-clock BCD hh:mm:ss timekeeper with fast minute/hour setting, hourly
// chime and NUM_ALARMS alarm slots driving a 2-bit buzzer code.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : timer_chime_if.slave
//          inputs  set_min, set_hour, alarm_en, alarm_time, alarm_stop
//          outputs h1..s2 (BCD time), tick (1 pulse/s), bee_in
//                  (00 silent, 01 short, 10 long, 11 alarm), alarm_hit
module timer_chime_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int FAST_DIV   = 25_000_000,
  parameter int NUM_ALARMS = 2,
  parameter int ALARM_LEN  = 30
) (
  input logic          clk,
  input logic          rst,
  timer_chime_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int RW = $clog2(ALARM_LEN + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(FAST_DIV - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [RW-1:0] RING_LOAD = RW'(ALARM_LEN);
  localparam logic [RW-1:0] RING_ONE  = RW'(1);

  typedef enum logic [1:0] {MODE_RUN, MODE_SETM, MODE_SETH} mode_e;
  typedef enum logic {ST_IDLE, ST_RING} state_e;

  // Packed {tens, ones} BCD pairs
  logic [7:0]            hour_q, hour_d;
  logic [7:0]            min_q,  min_d;
  logic [7:0]            sec_q,  sec_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [SW-1:0]         step_q, step_d;
  state_e                state_q, state_d;
  logic [RW-1:0]         ring_cnt_q, ring_cnt_d;
  logic [NUM_ALARMS-1:0] hit_q, hit_d;
  logic [1:0]            bee_q, bee_d;

  mode_e                 mode;
  logic                  step_fire;
  logic                  trigger;
  logic [NUM_ALARMS-1:0] match;
  logic [15:0]           slot;

  // Increment a 00..59 BCD pair with wrap to 00
  function automatic logic [7:0] inc_base60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Increment a 00..23 BCD pair with wrap to 00
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Malformed slots are simply never matched; with nibbles <= 9 a plain
  // 8-bit compare against the BCD limit is a numeric compare.
  function automatic logic slot_valid(input logic [15:0] s);
    return (s[15:12] <= 4'd9) && (s[11:8] <= 4'd9) &&
           (s[7:4]   <= 4'd9) && (s[3:0]  <= 4'd9) &&
           (s[15:8]  <= 8'h23) && (s[7:0] <= 8'h59);
  endfunction

  // Next-state logic: prescaler, time digits, set stepping, alarm FSM and
  // buzzer code. Alarm and buzzer look at next-state time so they change in
  // the same cycle as the digits.
  always_comb begin
    mode       = MODE_RUN;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    step_d     = '0;
    step_fire  = 1'b0;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    trigger    = 1'b0;
    match      = '0;
    slot       = '0;
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    hit_d      = hit_q;
    bee_d      = 2'b00;

    if (bus.set_min) begin
      mode = MODE_SETM;
    end else if (bus.set_hour) begin
      mode = MODE_SETH;
    end

    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
    tick_d  = (presc_d == PRESC_MAX);

    if (mode == MODE_RUN) begin
      if (tick_q) begin
        sec_d = inc_base60(sec_q);
        if (sec_q == 8'h59) begin
          min_d = inc_base60(min_q);
          if (min_q == 8'h59) begin
            hour_d = inc_hour(hour_q);
          end
        end
      end
    end else begin
      // Step counter free-runs while any set button is held; switching
      // between minute and hour setting keeps its phase.
      step_fire = (step_q == STEP_MAX);
      step_d    = step_fire ? '0 : step_q + STEP_ONE;
      sec_d     = 8'h00;
      if (step_fire) begin
        if (mode == MODE_SETM) begin
          min_d = inc_base60(min_q);
        end else begin
          hour_d = inc_hour(hour_q);
        end
      end
    end

    trigger = (mode == MODE_RUN) && tick_q && (sec_q == 8'h59);
    for (int k = 0; k < NUM_ALARMS; k++) begin
      slot     = bus.alarm_time[16*k +: 16];
      match[k] = trigger && bus.alarm_en[k] && slot_valid(slot) &&
                 (slot == {hour_d, min_d});
    end

    // Stop and set mode dominate so a simultaneous trigger is discarded
    if (bus.alarm_stop || (mode != MODE_RUN)) begin
      state_d    = ST_IDLE;
      ring_cnt_d = '0;
      hit_d      = '0;
    end else if (|match) begin
      state_d    = ST_RING;
      ring_cnt_d = RING_LOAD;
      hit_d      = hit_q | match;
    end else if ((state_q == ST_RING) && tick_q) begin
      if (ring_cnt_q == RING_ONE) begin
        state_d    = ST_IDLE;
        ring_cnt_d = '0;
        hit_d      = '0;
      end else begin
        ring_cnt_d = ring_cnt_q - RING_ONE;
      end
    end

    if (mode == MODE_RUN) begin
      if ((min_d == 8'h00) && (sec_d == 8'h00)) begin
        bee_d = 2'b10;
      end else if (state_d == ST_RING) begin
        bee_d = 2'b11;
      end else if ((min_d == 8'h59) && (sec_d[7:4] == 4'd5) && !sec_d[0]) begin
        bee_d = 2'b01;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_q     <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      step_q     <= '0;
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      hit_q      <= '0;
      bee_q      <= 2'b00;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      step_q     <= step_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      hit_q      <= hit_d;
      bee_q      <= bee_d;
    end
  end

  assign bus.h1        = hour_q[7:4];
  assign bus.h2        = hour_q[3:0];
  assign bus.m1        = min_q[7:4];
  assign bus.m2        = min_q[3:0];
  assign bus.s1        = sec_q[7:4];
  assign bus.s2        = sec_q[3:0];
  assign bus.tick      = tick_q;
  assign bus.bee_in    = bee_q;
  assign bus.alarm_hit = hit_q;

endmodule

// File: tb/tb_timer_chime_ctrl.sv
// tb_timer_chime_ctrl
// Directed and randomized bench for timer_chime_ctrl. A reference model keeps
// the time as seconds-of-day and derives tick, chime, alarm ringing and
// buzzer code from the clock-rule description; every cycle the DUT outputs
// are compared with it.
module tb_timer_chime_ctrl;

  localparam int TD = 4;
  localparam int FD = 2;
  localparam int NA = 2;
  localparam int AL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  timer_chime_if #(.NUM_ALARMS(NA)) bus();

  timer_chime_ctrl #(
    .TICK_DIV(TD), .FAST_DIV(FD), .NUM_ALARMS(NA), .ALARM_LEN(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int          n_edges;
  int          tod;
  int          set_cycles;
  int          ring_left;
  bit          ringing;
  logic [NA-1:0] m_hit;
  logic        m_tick;
  logic [1:0]  m_bee;

  function automatic logic [23:0] to_bcd(input int t);
    int hh, mm, ss;
    hh = t / 3600;
    mm = (t / 60) % 60;
    ss = t % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] slot_of(input int minute_of_day);
    int hh, mm;
    hh = minute_of_day / 60;
    mm = minute_of_day % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  // Minute-of-day a slot names, or -1 when it is not a legal time
  function automatic int slot_minute(input logic [15:0] s);
    int d3, d2, d1, d0;
    d3 = int'(s[15:12]);
    d2 = int'(s[11:8]);
    d1 = int'(s[7:4]);
    d0 = int'(s[3:0]);
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return -1;
    if (d3 * 10 + d2 > 23 || d1 * 10 + d0 > 59) return -1;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  task automatic modelReset();
    n_edges    = 0;
    tod        = 0;
    set_cycles = 0;
    ring_left  = 0;
    ringing    = 0;
    m_hit      = '0;
    m_tick     = 1'b0;
    m_bee      = 2'b00;
  endtask

  // One rising edge of the reference clock
  task automatic modelEdge();
    bit tick_ev;
    int mode;
    int hh, mm, ss;
    logic [NA-1:0] match;
    tick_ev = (n_edges % TD) == TD - 1;
    n_edges++;
    mode  = bus.set_min ? 1 : (bus.set_hour ? 2 : 0);
    match = '0;
    if (mode == 0) begin
      set_cycles = 0;
      if (tick_ev) tod = (tod + 1) % 86400;
    end else begin
      hh = tod / 3600;
      mm = (tod / 60) % 60;
      if (set_cycles % FD == FD - 1) begin
        if (mode == 1) mm = (mm + 1) % 60;
        else           hh = (hh + 1) % 24;
      end
      set_cycles++;
      tod = hh * 3600 + mm * 60;
    end
    if (mode == 0 && tick_ev && tod % 60 == 0) begin
      for (int k = 0; k < NA; k++) begin
        if (bus.alarm_en[k] && slot_minute(bus.alarm_time[16*k +: 16]) == tod / 60)
          match[k] = 1'b1;
      end
    end
    if (bus.alarm_stop || mode != 0) begin
      ringing   = 0;
      ring_left = 0;
      m_hit     = '0;
    end else if (match != '0) begin
      ringing   = 1;
      ring_left = AL;
      m_hit     = m_hit | match;
    end else if (ringing && tick_ev) begin
      ring_left--;
      if (ring_left == 0) begin
        ringing = 0;
        m_hit   = '0;
      end
    end
    m_tick = (n_edges % TD) == TD - 1;
    mm = (tod / 60) % 60;
    ss = tod % 60;
    if (mode != 0)                              m_bee = 2'b00;
    else if (mm == 0 && ss == 0)                m_bee = 2'b10;
    else if (ringing)                           m_bee = 2'b11;
    else if (mm == 59 && ss >= 50 && ss % 2 == 0) m_bee = 2'b01;
    else                                        m_bee = 2'b00;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("time", {bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}, to_bcd(tod));
    check("tick", {23'b0, bus.tick}, {23'b0, m_tick});
    check("bee_in", {22'b0, bus.bee_in}, {22'b0, m_bee});
    check("alarm_hit", {{(24-NA){1'b0}}, bus.alarm_hit}, {{(24-NA){1'b0}}, m_hit});
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic runUntil(input int target, input int limit);
    int c;
    c = 0;
    while (tod != target && c < limit) begin
      applyStimulus();
      c++;
    end
    vectors++;
    assert (tod == target) else begin
      errors++;
      $error("[TB] FAIL wait_timeout observed=%0d expected=%0d", tod, target);
    end
  endtask

  task automatic clearInputs();
    bus.set_min    = 1'b0;
    bus.set_hour   = 1'b0;
    bus.alarm_stop = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear before any clk edge
  task automatic asyncResetCheck();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setField(input bit is_min, input int steps);
    if (is_min) bus.set_min = 1'b1;
    else        bus.set_hour = 1'b1;
    runCycles(steps * FD);
    bus.set_min  = 1'b0;
    bus.set_hour = 1'b0;
  endtask

  task automatic presetTime(input int hh, input int mm);
    setField(1'b0, hh);
    setField(1'b1, mm);
  endtask

  initial begin
    int set_left;
    int target;
    logic [15:0] s0;
    logic [15:0] s1;

    bus.alarm_en   = '0;
    bus.alarm_time = '0;
    clearInputs();

    // Reset values, then one minute of free running
    doReset();
    runCycles(3);
    check("first_tick", {23'b0, bus.tick}, 24'd1);
    runCycles(240 - 3);
    check("one_minute", {bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}, 24'h000100);

    // Midnight rollover with top-of-hour chime
    doReset();
    presetTime(23, 59);
    runUntil(23 * 3600 + 59 * 60 + 58, 400);
    runUntil(23 * 3600 + 59 * 60 + 59, 10);
    runUntil(0, 10);
    check("midnight_bee", {22'b0, bus.bee_in}, 24'h2);
    runUntil(1, 10);
    check("after_midnight", {bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}, 24'h000001);
    check("after_midnight_bee", {22'b0, bus.bee_in}, 24'h0);

    // Short chime on even seconds of minute 59
    doReset();
    presetTime(12, 59);
    runUntil(12 * 3600 + 59 * 60 + 49, 400);
    runUntil(12 * 3600 + 59 * 60 + 50, 10);
    check("chime_50", {22'b0, bus.bee_in}, 24'h1);
    runUntil(12 * 3600 + 59 * 60 + 51, 10);
    check("chime_51", {22'b0, bus.bee_in}, 24'h0);
    runUntil(13 * 3600 + 1, 60);

    // Both set buttons: minutes win and wrap without touching hours
    doReset();
    presetTime(10, 58);
    runCycles(9);
    bus.set_min  = 1'b1;
    bus.set_hour = 1'b1;
    runCycles(2 * 61);
    check("set_both", {bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}, 24'h105900);
    clearInputs();
    runCycles(8);

    // Alarm ring to completion; disabled slot never reported
    doReset();
    bus.alarm_time = {16'h0730, 16'h0730};
    bus.alarm_en   = 2'b01;
    presetTime(7, 29);
    runUntil(7 * 3600 + 29 * 60 + 59, 400);
    runUntil(7 * 3600 + 30 * 60, 10);
    check("ring_bee", {22'b0, bus.bee_in}, 24'h3);
    check("ring_hit", {22'b0, bus.alarm_hit}, 24'h1);
    runUntil(7 * 3600 + 30 * 60 + 3, 20);
    check("ring_end_bee", {22'b0, bus.bee_in}, 24'h0);
    check("ring_end_hit", {22'b0, bus.alarm_hit}, 24'h0);

    // Alarm silenced by stop
    doReset();
    presetTime(7, 29);
    runUntil(7 * 3600 + 30 * 60 + 1, 400);
    bus.alarm_stop = 1'b1;
    applyStimulus();
    bus.alarm_stop = 1'b0;
    check("stop_bee", {22'b0, bus.bee_in}, 24'h0);
    runCycles(8);

    // Stop coinciding with the trigger keeps the FSM idle
    doReset();
    presetTime(7, 29);
    runUntil(7 * 3600 + 29 * 60 + 59, 400);
    while (!bus.tick) applyStimulus();
    bus.alarm_stop = 1'b1;
    applyStimulus();
    bus.alarm_stop = 1'b0;
    check("stop_at_trigger", {22'b0, bus.alarm_hit}, 24'h0);
    runCycles(8);

    // Asynchronous reset while ringing and while setting
    doReset();
    presetTime(7, 29);
    runUntil(7 * 3600 + 30 * 60, 400);
    runCycles(2);
    asyncResetCheck();
    check("rst_ring_bee", {22'b0, bus.bee_in}, 24'h0);
    runCycles(4);
    bus.set_hour = 1'b1;
    runCycles(5);
    asyncResetCheck();
    check("rst_set_time", {bus.h1, bus.h2, bus.m1, bus.m2, bus.s1, bus.s2}, 24'h000000);

    // Randomized: alarms aimed a minute or two ahead, random stops and set pulses
    set_left = 0;
    for (int r = 0; r < 14; r++) begin
      target = (tod / 60 + int'($urandom_range(1, 2))) % 1440;
      s0 = slot_of(target);
      s1 = ($urandom_range(0, 1) == 1) ? slot_of(target) : slot_of(int'($urandom_range(0, 1439)));
      if ($urandom_range(0, 5) == 0) s0[3:0] = 4'hA;
      if ($urandom_range(0, 5) == 0) s1[15:8] = 8'h24;
      bus.alarm_time = {s1, s0};
      bus.alarm_en   = 2'($urandom_range(0, 3));
      for (int c = 0; c < int'($urandom_range(200, 600)); c++) begin
        bus.alarm_stop = ($urandom_range(0, 60) == 0);
        if (set_left > 0) begin
          set_left--;
          if (set_left == 0) begin
            bus.set_min  = 1'b0;
            bus.set_hour = 1'b0;
          end
        end else if ($urandom_range(0, 150) == 0) begin
          set_left = int'($urandom_range(1, 5));
          if ($urandom_range(0, 1) == 1) bus.set_min = 1'b1;
          else                           bus.set_hour = 1'b1;
        end
        applyStimulus();
      end
      clearInputs();
      set_left = 0;
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
